// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the multi-cycle multdiv unit: accepts a mul/div in X,
// issues a one-cycle start pulse, stalls the pipe until the result (or a watchdog timeout).
//
// Handshake: an X-stage mul/div is accepted in IDLE when is_md & !flush. stall is held from
// that cycle until the result is ready. result/exception are only meaningful while
// result_valid=1, which lasts exactly one cycle.
module multdiv_sequencer #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             insn_valid,
    input  logic [4:0]       insn_opcode,
    input  logic [4:0]       insn_aluop,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_ready,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic [WIDTH-1:0] md_op_a,
    output logic [WIDTH-1:0] md_op_b,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_valid,
    output logic             timeout,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_mul_q, is_mul_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             timeout_q, timeout_d;
    logic             is_md;
    logic             accept;

    always_comb begin
        is_md = insn_valid && (insn_opcode == 5'b00000) &&
                ((insn_aluop == 5'b00110) || (insn_aluop == 5'b00111));
        accept = (state_q == IDLE) && is_md && !flush;

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mul_d  = is_mul_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        result_d  = result_q;
        exc_d     = exc_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = operand_a;
                    op_b_d   = operand_b;
                    is_mul_d = (insn_aluop == 5'b00110);
                    state_d  = ISSUE;
                end
            end
            // md_ready here still belongs to the previous operation, so it is not looked at.
            ISSUE: begin
                cnt_d   = '0;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (md_ready) begin
                    result_d = md_result;
                    exc_d    = md_exception;
                    state_d  = DONE;
                end else if (cnt_q == CW'(MAX_CYCLES - 1)) begin
                    result_d  = '0;
                    exc_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_mul_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mul_q  <= is_mul_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            timeout_q <= timeout_d;
        end
    end

    // The accept term is gated by reset so stall stays low while reset is held.
    assign stall        = (accept && reset) || (state_q == ISSUE) || (state_q == WAIT);
    assign ctrl_mult    = (state_q == ISSUE) && is_mul_q;
    assign ctrl_div     = (state_q == ISSUE) && !is_mul_q;
    assign result_valid = (state_q == DONE);
    assign md_op_a      = op_a_q;
    assign md_op_b      = op_b_q;
    assign result       = result_q;
    assign exception    = exc_q;
    assign timeout      = timeout_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: a behavioural multdiv responder plus
// per-scenario test tasks compared against plain-arithmetic expectations.
module tb_multdiv_sequencer;
    localparam int W       = 32;
    localparam int MAXC    = 40;
    localparam int MAXWAIT = 100;

    logic         clock, reset, insn_valid, flush;
    logic [4:0]   insn_opcode, insn_aluop;
    logic [W-1:0] operand_a, operand_b, md_result;
    logic         md_exception, md_ready;
    logic         ctrl_mult, ctrl_div, stall, exception, result_valid, timeout;
    logic [W-1:0] md_op_a, md_op_b, result;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_exc_q[$];

    multdiv_sequencer #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn_opcode(insn_opcode),
        .insn_aluop(insn_aluop), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_op_a(md_op_a), .md_op_b(md_op_b),
        .stall(stall), .result(result), .exception(exception), .result_valid(result_valid),
        .timeout(timeout), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_res(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        if (m) return a * b;
        if (b == 0) return '0;
        return a / b;
    endfunction

    function automatic logic ref_exc(input logic m, input logic [W-1:0] b);
        return !m && (b == 0);
    endfunction

    // Multdiv responder: after a start pulse, raises md_ready for one cycle on the
    // md_lat-th following cycle (md_lat == 0 means never); garbage data otherwise.
    int           md_lat = 0;
    int           k = 0;
    logic         pend = 1'b0;
    logic         pm = 1'b0;
    logic [W-1:0] pa = '0, pb = '0;
    always @(negedge clock) begin
        if (!reset) begin
            pend = 1'b0;
            md_ready = 1'b0;
        end else if (ctrl_mult || ctrl_div) begin
            pend = 1'b1; k = 0; pa = md_op_a; pb = md_op_b; pm = ctrl_mult;
            md_ready = 1'b0;
            md_result = $urandom;
        end else if (pend) begin
            k++;
            if (md_lat != 0 && k == md_lat) begin
                md_ready = 1'b1;
                md_result = ref_res(pm, pa, pb);
                md_exception = ref_exc(pm, pb);
                pend = 1'b0;
            end else begin
                md_ready = 1'b0;
                md_result = $urandom;
                md_exception = 1'(($urandom_range(0, 1)));
            end
        end else begin
            md_ready = 1'b0;
            md_result = $urandom;
            md_exception = 1'(($urandom_range(0, 1)));
        end
    end

    // Driver: presents one mul/div in X, then measures the run until result_valid.
    task automatic run_op(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          output int stall_n, output int mult_n, output int div_n, output int lat_n,
                          output logic got_rv, output logic dstall, output logic [W-1:0] res,
                          output logic exc);
        md_lat = lat;
        @(negedge clock);
        insn_valid = 1'b1; insn_opcode = 5'b00000;
        insn_aluop = mul ? 5'b00110 : 5'b00111;
        operand_a = a; operand_b = b;
        #1;
        stall_n = 0; mult_n = 0; div_n = 0; lat_n = 0;
        got_rv = 1'b0; dstall = 1'b0; res = '0; exc = 1'b0;
        for (int c = 0; c < MAXWAIT && !got_rv; c++) begin
            if (stall) stall_n++;
            if (ctrl_mult) mult_n++;
            if (ctrl_div) div_n++;
            @(negedge clock);
            if (c == 0) begin
                insn_valid = 1'b0;
                operand_a = $urandom;
                operand_b = $urandom;
            end
            #1;
            if (result_valid) begin
                got_rv = 1'b1; lat_n = c + 1; res = result; exc = exception; dstall = stall;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
        insn_valid = 1'b1; insn_opcode = 5'b00000; insn_aluop = 5'b00110;
        operand_a = 32'h1234; operand_b = 32'h5678;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({ctrl_mult, ctrl_div, stall, exception, result_valid, timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000",
                {ctrl_mult, ctrl_div, stall, exception, result_valid, timeout});
        end
        checks++;
        if ({md_op_a, md_op_b, result} !== '0) begin
            errors++; $display("FAIL reset_data: op_a %h op_b %h result %h want 0", md_op_a, md_op_b, result);
        end
        @(negedge clock);
        insn_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_decode();
        logic [7:0] tbl [6];
        tbl[0] = {1'b0, 5'b00110, 2'b00};
        tbl[1] = {1'b1, 5'b00101, 2'b00};
        tbl[2] = {1'b1, 5'b01110, 2'b00};
        tbl[3] = {1'b1, 5'b00110, 2'b01};
        tbl[4] = {1'b1, 5'b00111, 2'b01};
        tbl[5] = {1'b1, 5'b00110, 2'b10};
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            insn_valid = tbl[i][7];
            insn_aluop = tbl[i][6:2];
            flush = tbl[i][0];
            insn_opcode = tbl[i][1] ? 5'b00001 : 5'b00000;
            operand_a = $urandom; operand_b = $urandom;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL decode_stall[%0d]: got %b want 0", i, stall);
            end
            @(negedge clock);
            insn_valid = 1'b0; flush = 1'b0; insn_opcode = 5'b00000;
            #1;
            checks++;
            if ({ctrl_mult, ctrl_div, stall} !== 3'b000) begin
                errors++; $display("FAIL decode_noissue[%0d]: got %b want 000", i, {ctrl_mult, ctrl_div, stall});
            end
        end
    endtask

    task automatic test_basic_mul();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        run_op(1'b1, 32'd7, 32'd6, 4, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL mul_rv: got %b want 1", rv); end
        checks++; if (rs !== 32'd42) begin errors++; $display("FAIL mul_result: got %0d want 42", rs); end
        checks++; if (ex !== 1'b0) begin errors++; $display("FAIL mul_exc: got %b want 0", ex); end
        checks++; if (mn != 1 || dn != 0) begin errors++; $display("FAIL mul_pulses: mult %0d div %0d want 1 0", mn, dn); end
        checks++; if (sn != 6) begin errors++; $display("FAIL mul_stall_cycles: got %0d want 6", sn); end
        checks++; if (ln != 6) begin errors++; $display("FAIL mul_latency: got %0d want 6", ln); end
        checks++; if (ds !== 1'b0) begin errors++; $display("FAIL mul_done_stall: got %b want 0", ds); end
        @(negedge clock); #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_rv_one_cycle: got %b want 0", result_valid); end
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL mul_result_hold: got %0d want 42", result); end
        checks++;
        if (md_op_a !== 32'd7 || md_op_b !== 32'd6) begin
            errors++; $display("FAIL mul_ops_hold: got %0d %0d want 7 6", md_op_a, md_op_b);
        end
    endtask

    task automatic test_div_zero();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        run_op(1'b0, 32'd100, 32'd0, 3, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL div0_rv: got %b want 1", rv); end
        checks++; if (ex !== 1'b1) begin errors++; $display("FAIL div0_exc: got %b want 1", ex); end
        checks++; if (dn != 1 || mn != 0) begin errors++; $display("FAIL div0_pulses: mult %0d div %0d want 0 1", mn, dn); end
        checks++; if (ln != 5) begin errors++; $display("FAIL div0_latency: got %0d want 5", ln); end
    endtask

    task automatic test_flush();
        logic [W-1:0] prev; int rv_n, st_n;
        prev = result;
        md_lat = 5;
        @(negedge clock);
        insn_valid = 1'b1; insn_opcode = 5'b00000; insn_aluop = 5'b00110;
        operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clock);
        insn_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall: got %b want 1", stall); end
        @(negedge clock);
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", stall); end
        rv_n = 0; st_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (result_valid) rv_n++;
            if (stall) st_n++;
            @(negedge clock); #1;
        end
        checks++; if (rv_n != 0) begin errors++; $display("FAIL flush_no_rv: got %0d strobes want 0", rv_n); end
        checks++; if (st_n != 0) begin errors++; $display("FAIL flush_no_stall: got %0d cycles want 0", st_n); end
        checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_kept: got %h want %h", result, prev); end
    endtask

    task automatic test_ready_at_limit();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        run_op(1'b1, 32'd1000, 32'd77, MAXC, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rs !== 32'd77000 || ex !== 1'b0) begin errors++; $display("FAIL limit_result: got %0d/%b want 77000/0", rs, ex); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL limit_no_timeout: got %b want 0", timeout); end
        checks++; if (ln != MAXC + 2) begin errors++; $display("FAIL limit_latency: got %0d want %0d", ln, MAXC + 2); end
    endtask

    task automatic test_back_to_back();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        run_op(1'b1, 32'd123, 32'd456, 2, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rs !== 32'd56088 || mn != 1 || dn != 0) begin errors++; $display("FAIL b2b_mul: got %0d m%0d d%0d want 56088 m1 d0", rs, mn, dn); end
        run_op(1'b0, 32'd999, 32'd10, 1, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rs !== 32'd99 || ex !== 1'b0 || mn != 0 || dn != 1) begin errors++; $display("FAIL b2b_div: got %0d e%b m%0d d%0d want 99 e0 m0 d1", rs, ex, mn, dn); end
        checks++; if (ln != 3 || sn != 3) begin errors++; $display("FAIL b2b_div_timing: lat %0d stall %0d want 3 3", ln, sn); end
    endtask

    task automatic test_random();
        int sn, mn, dn, ln, lat; logic rv, ds, ex, m; logic [W-1:0] rs, a, b, er; logic ee;
        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            if (!m && $urandom_range(0, 3) == 0) b = '0;
            if (!m && $urandom_range(0, 1) == 1) b = b >> $urandom_range(16, 30);
            lat = $urandom_range(1, 7);
            exp_q.push_back(ref_res(m, a, b));
            exp_exc_q.push_back(ref_exc(m, b));
            run_op(m, a, b, lat, sn, mn, dn, ln, rv, ds, rs, ex);
            er = exp_q.pop_front();
            ee = exp_exc_q.pop_front();
            checks++;
            if (rv !== 1'b1 || rs !== er || ex !== ee) begin
                errors++; $display("FAIL rand_result[%0d]: got rv%b %h e%b want rv1 %h e%b", i, rv, rs, ex, er, ee);
            end
            checks++;
            if (mn != int'(m) || dn != int'(!m) || ln != lat + 2) begin
                errors++; $display("FAIL rand_timing[%0d]: m%0d d%0d lat %0d want m%0d d%0d lat %0d",
                    i, mn, dn, ln, m, !m, lat + 2);
            end
        end
    endtask

    task automatic test_timeout();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        run_op(1'b1, 32'd9, 32'd9, 0, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rv !== 1'b1 || rs !== '0 || ex !== 1'b1) begin errors++; $display("FAIL to_result: got rv%b %h e%b want rv1 0 e1", rv, rs, ex); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
        checks++; if (ln != MAXC + 2 || sn != MAXC + 2) begin errors++; $display("FAIL to_cycles: lat %0d stall %0d want %0d", ln, sn, MAXC + 2); end
        run_op(1'b1, 32'd11, 32'd3, 2, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rs !== 32'd33 || ex !== 1'b0) begin errors++; $display("FAIL to_after_op: got %0d e%b want 33 e0", rs, ex); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout); end
    endtask

    task automatic test_reset_mid_wait();
        int sn, mn, dn, ln; logic rv, ds, ex; logic [W-1:0] rs;
        md_lat = 10;
        @(negedge clock);
        insn_valid = 1'b1; insn_opcode = 5'b00000; insn_aluop = 5'b00111;
        operand_a = 32'hdead; operand_b = 32'h17;
        @(negedge clock);
        insn_valid = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ctrl_mult, ctrl_div, stall, exception, result_valid, timeout} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b want 000000",
                {ctrl_mult, ctrl_div, stall, exception, result_valid, timeout});
        end
        checks++;
        if ({md_op_a, md_op_b, result} !== '0) begin
            errors++; $display("FAIL rst_mid_data: op_a %h op_b %h result %h want 0", md_op_a, md_op_b, result);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_op(1'b1, 32'd250, 32'd4, 3, sn, mn, dn, ln, rv, ds, rs, ex);
        checks++; if (rv !== 1'b1 || rs !== 32'd1000 || ex !== 1'b0) begin errors++; $display("FAIL rst_after_op: got rv%b %0d e%b want rv1 1000 e0", rv, rs, ex); end
        checks++; if (mn != 1 || ln != 5 || timeout !== 1'b0) begin errors++; $display("FAIL rst_after_timing: m%0d lat %0d to%b want m1 lat 5 to0", mn, ln, timeout); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_basic_mul();
        test_div_zero();
        test_flush();
        test_ready_at_limit();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
